cohort_fifo_ring_ctrl: RTL and testbench

//  Multi-channel controller for memory-resident ring-buffer FIFOs in the cohort tile.
//  Per channel: holds base/length/element size and the head/tail/count state.

---
 rtl/cohort_fifo_ring_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cohort_fifo_ring_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cohort_fifo_ring_ctrl.sv
// Multi-channel ring-buffer FIFO controller: per-channel head/tail/count tracking and a
// round-robin, registered valid/ready port that issues load addresses for tail elements.
module cohort_fifo_ring_ctrl #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LEN_W  = 16,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic [2:0]        cfg_size_i,
  input  logic              push_valid_i,
  output logic              push_ready_o,
  input  logic [CH_W-1:0]   push_ch_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [CH_W-1:0]   req_ch_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [2:0]        req_size_o,
  output logic [NUM_CH-1:0] full_o,
  output logic [NUM_CH-1:0] empty_o
);

  logic [ADDR_W-1:0] base_q [NUM_CH];
  logic [LEN_W-1:0]  len_q  [NUM_CH];
  logic [2:0]        size_q [NUM_CH];
  logic [LEN_W-1:0]  head_q [NUM_CH];
  logic [LEN_W-1:0]  tail_q [NUM_CH];
  logic [LEN_W-1:0]  cnt_q  [NUM_CH];
  logic [CH_W-1:0]   rr_q;

  logic              req_valid_q;
  logic [CH_W-1:0]   req_ch_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [2:0]        req_size_q;

  logic [NUM_CH-1:0] en, full, eligible, push_hit, pop_hit, cfg_hit;
  logic              cfg_fire, push_fire, load;
  logic              grant_valid;
  logic [CH_W-1:0]   grant_ch;
  logic [ADDR_W-1:0] load_addr;
  logic [2:0]        cfg_size_clamped;

  function automatic logic [LEN_W-1:0] ptr_inc(input logic [LEN_W-1:0] ptr,
                                               input logic [LEN_W-1:0] len);
    return (ptr == len - LEN_W'(1)) ? '0 : ptr + LEN_W'(1);
  endfunction

  // Never reconfigure a channel whose element is sitting in the output register.
  assign cfg_ready_o      = !(req_valid_q && (req_ch_q == cfg_ch_i));
  assign cfg_fire         = cfg_valid_i && cfg_ready_o;
  assign cfg_size_clamped = (cfg_size_i > 3'd4) ? 3'd4 : cfg_size_i;

  assign push_ready_o = en[push_ch_i] && !full[push_ch_i] &&
                        !(cfg_valid_i && (cfg_ch_i == push_ch_i));
  assign push_fire    = push_valid_i && push_ready_o;

  always_comb begin
    en       = '0;
    full     = '0;
    eligible = '0;
    push_hit = '0;
    cfg_hit  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      en[i]       = (len_q[i] != '0);
      full[i]     = en[i] && (cnt_q[i] == len_q[i]);
      cfg_hit[i]  = cfg_fire && (cfg_ch_i == CH_W'(i));
      push_hit[i] = push_fire && (push_ch_i == CH_W'(i));
      // A channel being reconfigured this cycle must not also be popped.
      eligible[i] = en[i] && (cnt_q[i] != '0) && !cfg_hit[i];
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int unsigned     idx;
    logic [CH_W-1:0] cand;
    idx         = 0;
    cand        = '0;
    grant_valid = 1'b0;
    grant_ch    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx  = (int'(rr_q) + k) % NUM_CH;
      cand = CH_W'(idx);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_ch    = cand;
      end
    end
  end

  assign load      = (!req_valid_q || req_ready_i) && grant_valid;
  assign load_addr = base_q[grant_ch] + (ADDR_W'(tail_q[grant_ch]) << size_q[grant_ch]);

  always_comb begin
    pop_hit = '0;
    if (load) pop_hit[grant_ch] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
        size_q[i] <= '0;
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_hit[i]) begin
          base_q[i] <= cfg_base_i;
          len_q[i]  <= cfg_len_i;
          size_q[i] <= cfg_size_clamped;
          head_q[i] <= '0;
          tail_q[i] <= '0;
          cnt_q[i]  <= '0;
        end else begin
          if (push_hit[i]) head_q[i] <= ptr_inc(head_q[i], len_q[i]);
          if (pop_hit[i])  tail_q[i] <= ptr_inc(tail_q[i], len_q[i]);
          if (push_hit[i] && !pop_hit[i])      cnt_q[i] <= cnt_q[i] + LEN_W'(1);
          else if (!push_hit[i] && pop_hit[i]) cnt_q[i] <= cnt_q[i] - LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      req_valid_q <= 1'b0;
      req_ch_q    <= '0;
      req_addr_q  <= '0;
      req_size_q  <= '0;
    end else if (load) begin
      rr_q        <= grant_ch;
      req_valid_q <= 1'b1;
      req_ch_q    <= grant_ch;
      req_addr_q  <= load_addr;
      req_size_q  <= size_q[grant_ch];
    end else if (req_ready_i) begin
      req_valid_q <= 1'b0;
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_ch_o    = req_ch_q;
  assign req_addr_o  = req_addr_q;
  assign req_size_o  = req_size_q;
  assign full_o      = full;

  always_comb begin
    empty_o = '0;
    for (int i = 0; i < NUM_CH; i++) empty_o[i] = (cnt_q[i] == '0);
  end

endmodule

// File: tb/tb_cohort_fifo_ring_ctrl.sv
// Directed bench for cohort_fifo_ring_ctrl: hand-computed addresses, grant order and flags.
module tb_cohort_fifo_ring_ctrl;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [ADDR_W-1:0] cfg_base;
  logic [LEN_W-1:0]  cfg_len;
  logic [2:0]        cfg_size;
  logic              push_valid;
  logic              push_ready;
  logic [CH_W-1:0]   push_ch;
  logic              req_valid;
  logic              req_ready;
  logic [CH_W-1:0]   req_ch;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;

  int checks = 0;
  int errors = 0;

  cohort_fifo_ring_ctrl #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_ch_i     (cfg_ch),
    .cfg_base_i   (cfg_base),
    .cfg_len_i    (cfg_len),
    .cfg_size_i   (cfg_size),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .push_ch_i    (push_ch),
    .req_valid_o  (req_valid),
    .req_ready_i  (req_ready),
    .req_ch_o     (req_ch),
    .req_addr_o   (req_addr),
    .req_size_o   (req_size),
    .full_o       (full),
    .empty_o      (empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [CH_W-1:0] ch, input logic [ADDR_W-1:0] base,
                        input logic [LEN_W-1:0] len, input logic [2:0] size);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_base  = base;
    cfg_len   = len;
    cfg_size  = size;
    #1;
    check_eq("cfg_rdy", 64'(cfg_ready), 64'd1);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic push_try(input logic [CH_W-1:0] ch, input logic exp_rdy);
    push_valid = 1'b1;
    push_ch    = ch;
    #1;
    check_eq("push_rdy", 64'(push_ready), 64'(exp_rdy));
    tick();
    push_valid = 1'b0;
  endtask

  task automatic check_req(input string tag, input logic [CH_W-1:0] ch,
                           input logic [ADDR_W-1:0] addr);
    check_eq({tag, "_vld"}, 64'(req_valid), 64'd1);
    check_eq({tag, "_ch"}, 64'(req_ch), 64'(ch));
    check_eq({tag, "_addr"}, req_addr, addr);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_base   = '0;
    cfg_len    = '0;
    cfg_size   = '0;
    push_valid = 1'b0;
    push_ch    = '0;
    req_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset state
    check_eq("rst_vld", 64'(req_valid), 64'd0);
    check_eq("rst_empty", 64'(empty), 64'hF);
    check_eq("rst_full", 64'(full), 64'h0);
    check_eq("rst_cfg_rdy", 64'(cfg_ready), 64'd1);
    check_eq("rst_push_rdy", 64'(push_ready), 64'd0);
    rst_n = 1'b1;
    tick();

    // 2: ch0 len 3, 8-byte elements; first element loads into the held output register
    do_cfg(2'd0, 64'h1000, 16'd3, 3'd3);
    push_try(2'd0, 1'b1);
    push_try(2'd0, 1'b1);
    push_try(2'd0, 1'b1);
    push_try(2'd0, 1'b1);
    check_eq("t2_full", 64'(full), 64'h1);
    push_try(2'd0, 1'b0);
    check_req("t2_r0", 2'd0, 64'h1000);
    check_eq("t2_size", 64'(req_size), 64'd3);
    req_ready = 1'b1;
    tick();
    check_req("t2_r1", 2'd0, 64'h1008);
    tick();
    check_req("t2_r2", 2'd0, 64'h1010);
    tick();
    check_req("t2_wrap", 2'd0, 64'h1000);
    tick();
    check_eq("t2_drained", 64'(req_valid), 64'd0);
    check_eq("t2_empty", 64'(empty), 64'hF);
    push_try(2'd0, 1'b1);
    check_eq("t2_lat0", 64'(req_valid), 64'd0);
    tick();
    check_req("t2_lat1", 2'd0, 64'h1008);
    tick();
    check_eq("t2_idle", 64'(req_valid), 64'd0);

    // 3: round-robin between ch1 and ch2, back-to-back under ready
    req_ready = 1'b0;
    do_cfg(2'd1, 64'h2000, 16'd4, 3'd2);
    do_cfg(2'd2, 64'h3000, 16'd4, 3'd0);
    push_try(2'd1, 1'b1);
    push_try(2'd1, 1'b1);
    push_try(2'd2, 1'b1);
    push_try(2'd2, 1'b1);
    check_req("t3_a", 2'd1, 64'h2000);
    req_ready = 1'b1;
    tick();
    check_req("t3_b", 2'd2, 64'h3000);
    check_eq("t3_b_size", 64'(req_size), 64'd0);
    tick();
    check_req("t3_c", 2'd1, 64'h2004);
    tick();
    check_req("t3_d", 2'd2, 64'h3001);
    tick();
    check_eq("t3_idle", 64'(req_valid), 64'd0);

    // 4: same-edge push and pop-load leaves the count unchanged
    req_ready = 1'b0;
    push_try(2'd0, 1'b1);
    push_try(2'd0, 1'b1);
    push_try(2'd0, 1'b1);
    check_req("t4_held", 2'd0, 64'h1010);
    req_ready = 1'b1;
    push_try(2'd0, 1'b1);
    req_ready = 1'b0;
    check_req("t4_pp", 2'd0, 64'h1000);
    check_eq("t4_full0", 64'(full[0]), 64'd0);
    check_eq("t4_empty0", 64'(empty[0]), 64'd0);
    push_try(2'd0, 1'b1);
    check_eq("t4_full1", 64'(full[0]), 64'd1);
    push_try(2'd0, 1'b0);

    // 5: cfg/push collision, cfg blocked by held entry, clamped size
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_base  = 64'h2000;
    cfg_len   = 16'd4;
    cfg_size  = 3'd2;
    push_ch   = 2'd1;
    #1;
    check_eq("t5_coll", 64'(push_ready), 64'd0);
    cfg_valid = 1'b0;
    #1;
    check_eq("t5_nocoll", 64'(push_ready), 64'd1);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_base  = 64'h4000;
    cfg_len   = 16'd2;
    cfg_size  = 3'd7;
    #1;
    check_eq("t5_blk0", 64'(cfg_ready), 64'd0);
    req_ready = 1'b1;
    tick();
    check_eq("t5_blk1", 64'(cfg_ready), 64'd0);
    check_req("t5_d1", 2'd0, 64'h1008);
    tick();
    check_req("t5_d2", 2'd0, 64'h1010);
    tick();
    check_req("t5_d3", 2'd0, 64'h1000);
    tick();
    check_eq("t5_dvld", 64'(req_valid), 64'd0);
    check_eq("t5_rdy", 64'(cfg_ready), 64'd1);
    tick();
    cfg_valid = 1'b0;
    check_eq("t5_empty0", 64'(empty[0]), 64'd1);
    check_eq("t5_full0", 64'(full[0]), 64'd0);
    push_try(2'd0, 1'b1);
    push_try(2'd0, 1'b1);
    check_req("t5_s0", 2'd0, 64'h4000);
    check_eq("t5_size", 64'(req_size), 64'd4);
    tick();
    check_req("t5_s1", 2'd0, 64'h4010);
    tick();
    check_eq("t5_idle", 64'(req_valid), 64'd0);

    // 6: asynchronous reset with a request in flight
    req_ready = 1'b0;
    push_try(2'd0, 1'b1);
    tick();
    check_eq("t6_pre", 64'(req_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_vld", 64'(req_valid), 64'd0);
    check_eq("t6_empty", 64'(empty), 64'hF);
    check_eq("t6_full", 64'(full), 64'h0);
    push_ch = 2'd0;
    #1;
    check_eq("t6_push_rdy", 64'(push_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    push_ch = 2'd1;
    #1;
    check_eq("t6_dis1", 64'(push_ready), 64'd0);
    check_eq("t6_vld2", 64'(req_valid), 64'd0);
    check_eq("t6_cfg_rdy", 64'(cfg_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
